// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared 7-segment types and the active-high hex glyph table.
// Segment bit order is {a,b,c,d,e,f,g}, so seg[6] is segment a.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // All segments dark, in active-high terms
    localparam seg7_t SEG7_BLANK = 7'h00;

    // Active-high glyphs for nibbles 0..F
    localparam seg7_t SEG7_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,   // 0 1 2 3
        7'h33, 7'h5B, 7'h5F, 7'h70,   // 4 5 6 7
        7'h7F, 7'h7B, 7'h77, 7'h1F,   // 8 9 A b
        7'h4E, 7'h3D, 7'h4F, 7'h47    // C d E F
    };

    function automatic seg7_t seg7_hex(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: user-side load bus and display pin bundle for the scan driver.
// Optional decimal-point signals appear when SEG7_DP_EN is defined.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp;
    logic                    seg_dp;
`endif

    modport master (
        output value, digit_en, load,
`ifdef SEG7_DP_EN
        output dp,
        input  seg_dp,
`endif
        input  seg, an, digit_idx
    );

    modport slave (
        input  value, digit_en, load,
`ifdef SEG7_DP_EN
        input  dp,
        output seg_dp,
`endif
        output seg, an, digit_idx
    );

endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// seg7_hex_decode: combinational nibble-to-segment decode with output polarity applied.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter int SEG_ACT_LOW = 1
) (
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // Look up the glyph and invert it for common-anode (active-low) boards
    always_comb begin
        seg = (SEG_ACT_LOW != 0) ? ~seg7_hex(nibble) : seg7_hex(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed multi-digit 7-segment driver.
// Shadow-captures the digit nibbles on load, advances one digit every REFRESH_DIV
// clocks, and blanks the first cycle of each slot to suppress ghosting.
// Define SEG7_DP_EN to add per-digit decimal-point input dp and output seg_dp.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int IDX_N = 1 << IDX_W;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic             ACT_LOW  = 1'(SEG_ACT_LOW != 0);
    localparam seg7_t            SEG_OFF  = ACT_LOW ? ~SEG7_BLANK : SEG7_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACT_LOW}};

    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [NUM_DIGITS-1:0]   en_reg;
    logic [CNT_W-1:0]        div_cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    seg7_t                   seg_reg;
    seg7_t                   seg_next;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [NUM_DIGITS-1:0]   an_next;

    // Shadow contents padded to a power of two so the index mux is always in range
    logic [3:0]              nib_pad [IDX_N];
    logic [IDX_N-1:0]        en_pad;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              cur_nib;
    seg7_t                   dec_seg;
    logic                    slot_blank;

    genvar gi;
    generate
        for (gi = 0; gi < IDX_N; gi++) begin : g_pad
            if (gi < NUM_DIGITS) begin : g_live
                assign nib_pad[gi] = value_reg[4*gi +: 4];
                assign en_pad[gi]  = en_reg[gi];
            end else begin : g_fill
                assign nib_pad[gi] = 4'h0;
                assign en_pad[gi]  = 1'b0;
            end
        end
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
            assign an_sel[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign cur_nib = nib_pad[idx_reg];

    seg7_hex_decode #(
        .SEG_ACT_LOW (SEG_ACT_LOW)
    ) u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Capture the user value into the shadow on the load strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= '0;
            en_reg    <= '0;
        end else if (bus.load) begin
            value_reg <= bus.value;
            en_reg    <= bus.digit_en;
        end
    end

    // Refresh divider; each wrap hands the display to the next digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
        end else if (div_cnt_reg == CNT_LAST) begin
            div_cnt_reg <= '0;
            idx_reg     <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end else begin
            div_cnt_reg <= div_cnt_reg + CNT_W'(1);
        end
    end

    // Blank on the first cycle of a slot or when the selected digit is disabled
    always_comb begin
        slot_blank = (div_cnt_reg == '0) || !en_pad[idx_reg];
        seg_next   = slot_blank ? SEG_OFF : dec_seg;
        an_next    = slot_blank ? AN_OFF : (ACT_LOW ? ~an_sel : an_sel);
    end

    // Register the pin drive so the board sees glitch-free levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg <= SEG_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign bus.seg       = seg_reg;
    assign bus.an        = an_reg;
    assign bus.digit_idx = idx_reg;

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp_reg;
    logic [IDX_N-1:0]      dp_pad;
    logic                  seg_dp_reg;
    logic                  seg_dp_next;

    generate
        for (gi = 0; gi < IDX_N; gi++) begin : g_dp_pad
            if (gi < NUM_DIGITS) begin : g_live
                assign dp_pad[gi] = dp_reg[gi];
            end else begin : g_fill
                assign dp_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Decimal points are captured alongside the digit values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_reg <= '0;
        end else if (bus.load) begin
            dp_reg <= bus.dp;
        end
    end

    // Decimal point follows the same blanking as the segments
    always_comb begin
        seg_dp_next = (!slot_blank && dp_pad[idx_reg]) ? ~ACT_LOW : ACT_LOW;
    end

    // Registered decimal-point drive, aligned with seg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_dp_reg <= ACT_LOW;
        end else begin
            seg_dp_reg <= seg_dp_next;
        end
    end

    assign bus.seg_dp = seg_dp_reg;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit scanner (REFRESH_DIV=4) and a 1-digit
// scanner (REFRESH_DIV=3) checked every cycle against a slot-arithmetic model,
// plus hand-computed pins for scan order, enable mask, load-at-wrap and decode.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam int NA = 4;
    localparam int RA = 4;
    localparam int NB = 1;
    localparam int RB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(NA)) ifa ();
    seg7_scan_driver_if #(.NUM_DIGITS(NB)) ifb ();

    seg7_scan_driver #(.NUM_DIGITS(NA), .REFRESH_DIV(RA), .SEG_ACT_LOW(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    seg7_scan_driver #(.NUM_DIGITS(NB), .REFRESH_DIV(RB), .SEG_ACT_LOW(1)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Lit segments per hex digit, spelled as segment letters
    string segs_on [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] lit_bits(input logic [3:0] n);
        logic [6:0] b;
        string s;
        b = 7'h00;
        s = segs_on[n];
        for (int i = 0; i < s.len(); i++) b[6 - (int'(s[i]) - 97)] = 1'b1;
        return b;
    endfunction

    // Expected pins after e clock edges since reset release (active-low board)
    task automatic expect_out(input int n, input int r, input int e,
                              input logic [15:0] val, input logic [3:0] en, input logic [3:0] dp,
                              output logic [6:0] seg, output logic [3:0] an,
                              output logic dot, output int idx);
        int ph;
        int dg;
        seg = 7'h7F;
        an  = 4'hF;
        dot = 1'b1;
        idx = (e / r) % n;
        if (e > 0) begin
            ph = (e - 1) % r;
            dg = ((e - 1) / r) % n;
            if (ph != 0 && en[dg]) begin
                seg    = ~lit_bits(val[4*dg +: 4]);
                an[dg] = 1'b0;
                dot    = ~dp[dg];
            end
        end
    endtask

    // Model state: edge count and shadow contents, plus shadow as seen one edge later
    int          m_edges = 0;
    logic [15:0] a_sh_val = '0, a_shown_val = '0;
    logic [3:0]  a_sh_en = '0, a_shown_en = '0, a_sh_dp = '0, a_shown_dp = '0;
    logic [15:0] b_sh_val = '0, b_shown_val = '0;
    logic [3:0]  b_sh_en = '0, b_shown_en = '0, b_sh_dp = '0, b_shown_dp = '0;
    logic [3:0]  a_dp_in, b_dp_in;

`ifdef SEG7_DP_EN
    assign a_dp_in = ifa.dp;
    assign b_dp_in = {3'b000, ifb.dp};
`else
    assign a_dp_in = 4'h0;
    assign b_dp_in = 4'h0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges <= 0;
            a_sh_val <= '0; a_sh_en <= '0; a_sh_dp <= '0;
            a_shown_val <= '0; a_shown_en <= '0; a_shown_dp <= '0;
            b_sh_val <= '0; b_sh_en <= '0; b_sh_dp <= '0;
            b_shown_val <= '0; b_shown_en <= '0; b_shown_dp <= '0;
        end else begin
            m_edges <= m_edges + 1;
            if (ifa.load) begin
                a_sh_val <= ifa.value; a_sh_en <= ifa.digit_en; a_sh_dp <= a_dp_in;
            end
            if (ifb.load) begin
                b_sh_val <= {12'h000, ifb.value}; b_sh_en <= {3'b000, ifb.digit_en}; b_sh_dp <= b_dp_in;
            end
            a_shown_val <= a_sh_val; a_shown_en <= a_sh_en; a_shown_dp <= a_sh_dp;
            b_shown_val <= b_sh_val; b_shown_en <= b_sh_en; b_shown_dp <= b_sh_dp;
        end
    end

    // Every-cycle comparison of both scanners against the model
    always @(negedge clk) begin
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        int         ei;
        expect_out(NA, RA, m_edges, a_shown_val, a_shown_en, a_shown_dp, es, ea, ed, ei);
        check("a_seg", ifa.seg, es);
        check("a_an", ifa.an, ea);
        check("a_idx", ifa.digit_idx, ei);
`ifdef SEG7_DP_EN
        check("a_dp", ifa.seg_dp, ed);
`endif
        expect_out(NB, RB, m_edges, b_shown_val, b_shown_en, b_shown_dp, es, ea, ed, ei);
        check("b_seg", ifb.seg, es);
        check("b_an", ifb.an, ea[0]);
        check("b_idx", ifb.digit_idx, ei);
`ifdef SEG7_DP_EN
        check("b_dp", ifb.seg_dp, ed);
`endif
    end

    task automatic wait_e(input int e);
        int guard;
        guard = 0;
        while (m_edges < e && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (m_edges != e) begin
            failures++;
            $display("FAIL wait_e actual=%0d required=%0d", m_edges, e);
        end
    endtask

    task automatic pin_a(input string name, input int e, input logic [6:0] seg, input logic [3:0] an);
        wait_e(e);
        check({name, "_seg"}, ifa.seg, seg);
        check({name, "_an"}, ifa.an, an);
        $display("pin %s e=%0d seg=%02h an=%04b", name, e, ifa.seg, ifa.an);
    endtask

    task automatic set_dp_a(input logic [3:0] d);
`ifdef SEG7_DP_EN
        ifa.dp = d;
`else
        if (d != 4'h0) $display("note dp=%04b ignored (no dp)", d);
`endif
    endtask

    task automatic pin_dp(input string name, input logic exp);
`ifdef SEG7_DP_EN
        check(name, ifa.seg_dp, exp);
`else
        if (exp === 1'bx) $display("note %s", name);
`endif
    endtask

    // Load one B nibble, then confirm three consecutive scan cycles: one blank, two glyphs
    task automatic sweep_pin(input logic [3:0] n, input logic [6:0] glyph);
        int nglyph;
        int nblank;
        ifb.value = n; ifb.digit_en = 1'b1; ifb.load = 1'b1;
        @(negedge clk);
        ifb.load = 1'b0;
        @(negedge clk);
        nglyph = 0;
        nblank = 0;
        for (int i = 0; i < RB; i++) begin
            if (ifb.seg == glyph && ifb.an == 1'b0) nglyph++;
            if (ifb.seg == 7'h7F && ifb.an == 1'b1) nblank++;
            if (i < RB - 1) @(negedge clk);
        end
        check("sweep_glyph_cycles", nglyph, RB - 1);
        check("sweep_blank_cycles", nblank, 1);
        $display("sweep nibble=%h glyph=%02h seen=%0d blank=%0d", n, glyph, nglyph, nblank);
    endtask

    initial begin
        ifa.value = '0; ifa.digit_en = '0; ifa.load = 1'b0;
        ifb.value = '0; ifb.digit_en = '0; ifb.load = 1'b0;
`ifdef SEG7_DP_EN
        ifa.dp = '0; ifb.dp = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_seg", ifa.seg, 7'h7F);
        check("rst_an", ifa.an, 4'hF);
        check("rst_idx", ifa.digit_idx, 0);
        $display("reset seg=%02h an=%04b idx=%0d", ifa.seg, ifa.an, ifa.digit_idx);

        // Scan order: digit 0 is the rightmost nibble (4), then 3, 2, 1
        rst = 1'b0;
        ifa.value = 16'h1234; ifa.digit_en = 4'hF; ifa.load = 1'b1;
        set_dp_a(4'b0010);
        @(negedge clk);
        ifa.load = 1'b0;
        pin_a("scan_d0", 2, 7'h4C, 4'b1110);
        pin_dp("scan_dp_d0", 1'b1);
        pin_a("scan_blank1", 5, 7'h7F, 4'hF);
        pin_dp("scan_dp_blank", 1'b1);
        pin_a("scan_d1", 6, 7'h06, 4'b1101);
        pin_dp("scan_dp_d1", 1'b0);
        pin_a("scan_d2", 10, 7'h12, 4'b1011);
        pin_a("scan_d3", 14, 7'h4F, 4'b0111);
        pin_a("scan_wrap_blank", 17, 7'h7F, 4'hF);
        pin_a("scan_d0_again", 18, 7'h4C, 4'b1110);

        // Asynchronous reset mid-slot
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_seg", ifa.seg, 7'h7F);
        check("async_rst_an", ifa.an, 4'hF);
        check("async_rst_idx", ifa.digit_idx, 0);
        $display("async reset seg=%02h an=%04b idx=%0d", ifa.seg, ifa.an, ifa.digit_idx);
        repeat (2) @(negedge clk);
        check("held_rst_seg", ifa.seg, 7'h7F);
        check("held_rst_an", ifa.an, 4'hF);

        // Enable mask 0101: digits 1 and 3 stay dark for their whole slot
        rst = 1'b0;
        ifa.value = 16'h1234; ifa.digit_en = 4'b0101; ifa.load = 1'b1;
        set_dp_a(4'b0010);
        @(negedge clk);
        ifa.load = 1'b0;
        pin_a("mask_d0", 2, 7'h4C, 4'b1110);
        pin_a("mask_d1", 6, 7'h7F, 4'hF);
        pin_a("mask_d1_late", 8, 7'h7F, 4'hF);
        pin_a("mask_d2", 10, 7'h12, 4'b1011);
        pin_a("mask_d3", 14, 7'h7F, 4'hF);

        // Load sampled on the edge where the divider wraps (edge 20)
        wait_e(19);
        ifa.value = 16'hABCD; ifa.digit_en = 4'hF; ifa.load = 1'b1;
        set_dp_a(4'b0010);
        @(negedge clk);
        ifa.load = 1'b0;
        pin_a("wrap_old_tail", 20, 7'h4C, 4'b1110);
        pin_a("wrap_blank", 21, 7'h7F, 4'hF);
        pin_a("wrap_new_d1", 22, 7'h31, 4'b1101);
        pin_dp("wrap_dp_d1", 1'b0);
        pin_a("wrap_new_d1_end", 24, 7'h31, 4'b1101);

        // Decode sweep on the single-digit scanner
        for (int n = 0; n < 16; n++) begin
            ifb.value = 4'(n); ifb.digit_en = 1'b1; ifb.load = 1'b1;
            @(negedge clk);
            ifb.load = 1'b0;
            repeat (2 * RB) @(negedge clk);
            $display("decode nibble=%h seg=%02h", n, ifb.seg);
        end
        sweep_pin(4'hF, 7'h38);
        sweep_pin(4'h8, 7'h00);
        sweep_pin(4'h1, 7'h4F);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
